// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side signal bundle for if_fetch_ctrl.
// Covers the instruction ROM port, pipeline control from later stages,
// the IF/ID register outputs and the debug ROM-read handshake.
// The master modport is the fetch controller; slave is everything around it.
interface if_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 6
);

  // Instruction ROM port (combinational read)
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_dout;

  // Pipeline control from hazard unit / EX stage
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;

  // Fetch state and IF/ID register
  logic [31:0]       pc;
  logic [31:0]       if_id_pc;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
  logic              halted;

  // Debug ROM read handshake
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [31:0]       dbg_data;

  modport master (
    output rom_addr,
    input  rom_dout,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output pc,
    output if_id_pc,
    output if_id_instr,
    output if_id_valid,
    output halted,
    input  dbg_req,
    input  dbg_addr,
    output dbg_ack,
    output dbg_data
  );

  modport slave (
    input  rom_addr,
    output rom_dout,
    output stall,
    output redirect,
    output redirect_pc,
    input  pc,
    input  if_id_pc,
    input  if_id_instr,
    input  if_id_valid,
    input  halted,
    output dbg_req,
    output dbg_addr,
    input  dbg_ack,
    input  dbg_data
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer for the pipelined RV32I core.
// Owns the PC, drives the instruction ROM address, loads the IF/ID register
// and applies redirect/stall from later stages. A jal-to-self fetch parks the
// sequencer in HALT. The single ROM read port is lent to a debug requester
// only in cycles where fetch does not need it (HALT, or a plain stall).
module if_fetch_ctrl #(
  parameter int unsigned ADDR_W      = 6,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          HALT_DETECT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  if_fetch_ctrl_if.master bus
);

  typedef enum logic [0:0] {
    StRun,
    StHalt
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] if_id_pc_q;
  logic [31:0] if_id_instr_q;
  logic        if_id_valid_q;
  logic        dbg_ack_q;
  logic [31:0] dbg_data_q;

  logic        dbg_gnt;
  logic        halt_cond;
  logic        same_word;
  logic [31:0] pc_target;

  // Debug read gets the ROM only when fetch is idle this cycle; a pending ack
  // blocks a second grant so each request yields exactly one pulse.
  always_comb begin
    dbg_gnt = bus.dbg_req & ~dbg_ack_q &
              ((state_q == StHalt) | (bus.stall & ~bus.redirect));
  end

  // ROM address mux: debug address in granted cycles, else the fetch word.
  always_comb begin
    if (dbg_gnt) begin
      bus.rom_addr = bus.dbg_addr;
    end else begin
      bus.rom_addr = pc_q[ADDR_W+1:2];
    end
  end

  // Halt idiom decode (jal x?, 0) and redirect target handling.
  always_comb begin
    halt_cond = HALT_DETECT && (bus.rom_dout[6:0] == 7'h6F) &&
                (bus.rom_dout[31:12] == 20'h0_0000);
    pc_target = {bus.redirect_pc[31:2], 2'b00};
    same_word = (bus.redirect_pc[31:2] == pc_q[31:2]);
  end

  // Sequencer state, PC, IF/ID register and debug response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_valid_q <= 1'b0;
      dbg_ack_q     <= 1'b0;
      dbg_data_q    <= 32'h0;
    end else begin
      // Debug completion runs independently of the fetch priority chain.
      dbg_ack_q <= dbg_gnt;
      if (dbg_gnt) begin
        dbg_data_q <= bus.rom_dout;
      end

      if (bus.redirect) begin
        // Redirect overrides stall and beats a same-cycle halt fetch.
        pc_q          <= pc_target;
        if_id_pc_q    <= 32'h0;
        if_id_instr_q <= 32'h0;
        if_id_valid_q <= 1'b0;
        if (state_q == StHalt && !same_word) begin
          state_q <= StRun;
        end
      end else if (bus.stall) begin
        // Hold everything.
      end else if (state_q == StRun) begin
        if_id_pc_q    <= pc_q;
        if_id_instr_q <= bus.rom_dout;
        if_id_valid_q <= 1'b1;
        if (halt_cond) begin
          // The jal still enters IF/ID; PC stays on it.
          state_q <= StHalt;
        end else begin
          pc_q <= pc_q + 32'd4;
        end
      end else begin
        // Parked: feed bubbles downstream.
        if_id_instr_q <= 32'h0;
        if_id_valid_q <= 1'b0;
      end
    end
  end

  // Registered outputs.
  always_comb begin
    bus.pc          = pc_q;
    bus.if_id_pc    = if_id_pc_q;
    bus.if_id_instr = if_id_instr_q;
    bus.if_id_valid = if_id_valid_q;
    bus.halted      = (state_q == StHalt);
    bus.dbg_ack     = dbg_ack_q;
    bus.dbg_data    = dbg_data_q;
  end

  // Low redirect bits are ignored by design.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: free run, stall with debug read,
// redirect, halt/resume, debug starvation and asynchronous reset.
module tb_if_fetch_ctrl;

  localparam int unsigned AW = 6;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [31:0] rom [64];

  if_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

  if_fetch_ctrl #(
    .ADDR_W     (AW),
    .RESET_PC   (32'h0000_0000),
    .HALT_DETECT(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.rom_dout = rom[bus.rom_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0] = 32'h00003f37;
    rom[1] = 32'h02000fe7;
    rom[5] = 32'h00432e03;
    rom[7] = 32'h00000f6f;

    rst_n           = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.dbg_req     = 1'b0;
    bus.dbg_addr    = '0;
    #2;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_if_id_pc", bus.if_id_pc, 32'h0);
    check("rst_instr", bus.if_id_instr, 32'h0);
    check("rst_valid", {31'h0, bus.if_id_valid}, 32'h0);
    check("rst_halted", {31'h0, bus.halted}, 32'h0);
    check("rst_ack", {31'h0, bus.dbg_ack}, 32'h0);
    check("rst_data", bus.dbg_data, 32'h0);
    check("rst_rom_addr", {26'h0, bus.rom_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Free run
    tick();
    check("run1_if_id_pc", bus.if_id_pc, 32'h0);
    check("run1_instr", bus.if_id_instr, 32'h00003f37);
    check("run1_valid", {31'h0, bus.if_id_valid}, 32'h1);
    check("run1_pc", bus.pc, 32'h4);
    tick();
    check("run2_if_id_pc", bus.if_id_pc, 32'h4);
    check("run2_instr", bus.if_id_instr, 32'h02000fe7);
    check("run2_pc", bus.pc, 32'h8);

    // Stall 3 cycles with a debug read of word 5
    bus.stall    = 1'b1;
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 6'd5;
    #1;
    check("stall_gnt_addr", {26'h0, bus.rom_addr}, 32'h5);
    tick();
    check("stall1_pc", bus.pc, 32'h8);
    check("stall1_instr", bus.if_id_instr, 32'h02000fe7);
    check("stall1_ack", {31'h0, bus.dbg_ack}, 32'h1);
    check("stall1_data", bus.dbg_data, 32'h00432e03);
    bus.dbg_req = 1'b0;
    #1;
    check("stall1_fetch_addr", {26'h0, bus.rom_addr}, 32'h2);
    tick();
    check("stall2_pc", bus.pc, 32'h8);
    check("stall2_ack", {31'h0, bus.dbg_ack}, 32'h0);
    tick();
    check("stall3_pc", bus.pc, 32'h8);
    check("stall3_if_id_pc", bus.if_id_pc, 32'h4);
    check("stall3_instr", bus.if_id_instr, 32'h02000fe7);
    check("stall3_valid", {31'h0, bus.if_id_valid}, 32'h1);
    check("stall3_ack", {31'h0, bus.dbg_ack}, 32'h0);

    // Stall + redirect: redirect wins, no debug grant
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0022;
    bus.dbg_req     = 1'b1;
    #1;
    check("redir_no_gnt", {26'h0, bus.rom_addr}, 32'h2);
    tick();
    check("redir_pc", bus.pc, 32'h20);
    check("redir_valid", {31'h0, bus.if_id_valid}, 32'h0);
    check("redir_instr", bus.if_id_instr, 32'h0);
    check("redir_ack", {31'h0, bus.dbg_ack}, 32'h0);

    // Debug starvation while running
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("starve_ack", {31'h0, bus.dbg_ack}, 32'h0);
    end
    check("starve_pc", bus.pc, 32'h48);

    // Jump back to 0x08 and run into the halt at 0x1C
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0008;
    tick();
    check("jmp8_pc", bus.pc, 32'h8);
    bus.redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pre_halt_ack", {31'h0, bus.dbg_ack}, 32'h0);
    end
    check("pre_halt_pc", bus.pc, 32'h1c);
    check("pre_halt_halted", {31'h0, bus.halted}, 32'h0);
    tick();
    check("halt_instr", bus.if_id_instr, 32'h00000f6f);
    check("halt_if_id_pc", bus.if_id_pc, 32'h1c);
    check("halt_valid", {31'h0, bus.if_id_valid}, 32'h1);
    check("halt_pc", bus.pc, 32'h1c);
    check("halt_halted", {31'h0, bus.halted}, 32'h1);
    check("halt_ack", {31'h0, bus.dbg_ack}, 32'h0);
    #1;
    check("halt_gnt_addr", {26'h0, bus.rom_addr}, 32'h5);
    tick();
    check("halt_dbg_ack", {31'h0, bus.dbg_ack}, 32'h1);
    check("halt_dbg_data", bus.dbg_data, 32'h00432e03);
    check("halt_bubble_valid", {31'h0, bus.if_id_valid}, 32'h0);
    check("halt_bubble_instr", bus.if_id_instr, 32'h0);
    check("halt_hold_pc", bus.pc, 32'h1c);
    bus.dbg_req = 1'b0;
    tick();
    check("halt_ack_drop", {31'h0, bus.dbg_ack}, 32'h0);
    check("halt_still", {31'h0, bus.halted}, 32'h1);

    // Redirect to self keeps HALT; elsewhere resumes
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_001c;
    tick();
    check("self_redir_halted", {31'h0, bus.halted}, 32'h1);
    check("self_redir_pc", bus.pc, 32'h1c);
    bus.redirect_pc = 32'h0000_0008;
    tick();
    check("resume_halted", {31'h0, bus.halted}, 32'h0);
    check("resume_pc", bus.pc, 32'h8);
    bus.redirect = 1'b0;
    tick();
    check("resume_if_id_pc", bus.if_id_pc, 32'h8);
    check("resume_valid", {31'h0, bus.if_id_valid}, 32'h1);
    check("resume_pc_inc", bus.pc, 32'hc);

    // Redirect in the same cycle as a halt-idiom fetch: no halt
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_001c;
    tick();
    check("race_setup_pc", bus.pc, 32'h1c);
    bus.redirect_pc = 32'h0000_0010;
    tick();
    check("race_halted", {31'h0, bus.halted}, 32'h0);
    check("race_pc", bus.pc, 32'h10);
    check("race_valid", {31'h0, bus.if_id_valid}, 32'h0);
    bus.redirect = 1'b0;
    tick();
    check("race_run_pc", bus.pc, 32'h14);

    // Async reset between edges, with a debug ack outstanding
    bus.stall   = 1'b1;
    bus.dbg_req = 1'b1;
    tick();
    check("pre_rst_ack", {31'h0, bus.dbg_ack}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ack", {31'h0, bus.dbg_ack}, 32'h0);
    check("arst_data", bus.dbg_data, 32'h0);
    check("arst_pc", bus.pc, 32'h0);
    check("arst_if_id_pc", bus.if_id_pc, 32'h0);
    check("arst_instr", bus.if_id_instr, 32'h0);
    check("arst_valid", {31'h0, bus.if_id_valid}, 32'h0);
    check("arst_halted", {31'h0, bus.halted}, 32'h0);
    bus.dbg_req = 1'b0;
    bus.stall   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_instr", bus.if_id_instr, 32'h00003f37);
    check("post_rst_pc", bus.pc, 32'h4);
    check("post_rst_ack", {31'h0, bus.dbg_ack}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipelined RV32I core.
- Owns the PC and drives the combinational instruction ROM address.
- Loads the IF/ID pipeline register and applies stall, flush and branch/jump redirect from later stages.
- Detects the self-loop halt idiom (jal rd,0) and arbitrates the single ROM read port between fetch and a debug read requester.

Parameters:
- ADDR_W, 6, ROM word-address width (ROM depth 2^ADDR_W words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_DETECT, 1, 1 enables jal-to-self halt detection; 0 means the block never enters HALT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_addr  out  ADDR_W  word address to instruction ROM (combinational).
- rom_dout  in  32  ROM read data, valid in the same cycle as rom_addr.
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect  in  1  EX stage: branch taken or jump; flush IF/ID.
- redirect_pc  in  32  target byte address; bits [1:0] are ignored.
- pc  out  32  current fetch PC.
- if_id_pc  out  32  PC of the instruction held in IF/ID.
- if_id_instr  out  32  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  high while in state HALT.
- dbg_req  in  1  debug ROM read request; held high until dbg_ack.
- dbg_addr  in  ADDR_W  debug word address; stable while dbg_req is high.
- dbg_ack  out  1  one-cycle pulse: dbg_data is valid.
- dbg_data  out  32  registered debug read data.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; if_id_pc=0; if_id_instr=0; if_id_valid=0.
  - State=RUN; dbg_ack=0; dbg_data=0.
- States: RUN, HALT. halted = (state==HALT).
- Fetch address: the fetch address is pc[ADDR_W+1:2]. Upper PC bits are ignored, so the PC wraps modulo the ROM size. Out-of-range data is whatever the ROM returns (0 is treated as a nop).
- Debug grant (combinational): dbg_gnt = dbg_req & ~dbg_ack & (state==HALT | (stall & ~redirect)).
  - rom_addr = dbg_gnt ? dbg_addr : pc[ADDR_W+1:2].
  - A fetch never uses the ROM in a granted cycle.
- Debug completion: on the edge after a grant, dbg_data <= rom_dout and dbg_ack <= 1 for exactly one cycle. Latency is 1 cycle from grant to ack.
- Debug starvation: if stall is low and state is RUN, a debug request waits indefinitely. Fetch always has priority.
- Update priority, per edge, highest first:
  1. redirect=1 (overrides stall):
     - pc <= {redirect_pc[31:2],2'b00}; if_id_valid<=0; if_id_instr<=0; if_id_pc<=0.
     - In HALT: if redirect_pc[31:2]==pc[31:2], stay in HALT; otherwise go to RUN.
  2. stall=1: pc and IF/ID hold their values; state holds.
  3. RUN, not stalled:
     - if_id_pc<=pc; if_id_instr<=rom_dout; if_id_valid<=1; pc<=pc+4 (32-bit wrap).
     - Halt condition: HALT_DETECT=1, rom_dout[6:0]==7'h6F and rom_dout[31:12]==0.
     - On the halt condition the jal is still loaded into IF/ID, but pc is held (not incremented) and state becomes HALT.
  4. HALT, not stalled: if_id_valid<=0 and if_id_instr<=0 (bubbles); pc holds.
- A redirect and a halt-condition fetch in the same cycle: the redirect wins, and no halt occurs.
- Reset mid-debug-transaction: the pending request is dropped with no ack. The requester re-issues after reset.

Test Plan:
- Reset, then free run with ROM word0=32'h00003f37, word1=32'h02000fE7:
  - 1st edge: if_id_pc=0, if_id_instr=32'h00003f37, valid=1, pc=4.
  - 2nd edge: if_id_instr=32'h02000fE7, pc=8.
- Stall held 3 cycles at pc=8: pc, if_id_* unchanged for 3 edges. With dbg_req=1 and dbg_addr=5 during the stall: the stall's first cycle is the grant cycle, ack follows on the next edge with dbg_data=32'h00432e03, and only one ack pulse occurs.
- stall=1 and redirect=1 with redirect_pc=32'h0000_0022: next pc=32'h20, if_id_valid=0, if_id_instr=0, no debug grant.
- Fetch at pc=32'h1C with word7=32'h00000f6f:
  - if_id_instr=32'h00000f6f, valid=1, pc stays 32'h1C, halted=1.
  - Following cycles: valid=0.
  - redirect_pc=32'h1C: stays halted.
  - redirect_pc=32'h08: halted=0, fetch resumes at 32'h08.
- Run with stall=0, redirect=0 and dbg_req=1: dbg_ack stays 0 for 10 cycles. After the halt at 32'h1C, ack arrives 1 cycle after the grant.
- Assert rst_n=0 mid-run and mid-debug, asynchronously between edges: all outputs immediately return to reset values, including dbg_ack=0.
